// File: rtl/synth_pkg.sv
// Shared constants for the voice allocator: widths, state encoding and the
// retrigger gap derived from the synthesis clock and the audio sample rate.
package synth_pkg;

  localparam int NVOICES_DEF = 3;
  localparam int NOTE_W      = 7;
  localparam int FREQ_W      = 16;

  // One 48 kHz sample period at 24.576 MHz is 512 clocks.
  localparam int CLK_HZ         = 24_576_000;
  localparam int SAMPLE_HZ      = 48_000;
  localparam int RETRIG_GAP_DEF = CLK_HZ / SAMPLE_HZ;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_APPLY  = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [FREQ_W-1:0] freq;
  } event_t;

endpackage

// File: rtl/voice_alloc_if.sv
// Note-event handshake between a MIDI front end and the voice allocator.
interface voice_alloc_if;
  import synth_pkg::*;

  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;
  logic [FREQ_W-1:0] ev_freq;

  modport master (output ev_valid, output ev_on, output ev_note, output ev_freq,
                  input ev_ready);
  modport slave  (input ev_valid, input ev_on, input ev_note, input ev_freq,
                  output ev_ready);

endinterface

// File: rtl/voice_lru.sv
// Least-recently-assigned tracking: touching a voice makes it rank 0 and ages
// every voice that was more recent than it, so ranks stay a permutation.
module voice_lru
  import synth_pkg::*;
#(
  parameter int NVOICES = NVOICES_DEF,
  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1
) (
  input  logic                 clk24,
  input  logic                 rst,
  input  logic                 touch,
  input  logic [IW-1:0]        touch_idx,
  output logic [NVOICES*IW-1:0] ranks
);

  logic [IW-1:0] rank_q [NVOICES];
  logic [IW-1:0] old_rank;

  assign old_rank = rank_q[touch_idx];

  always_ff @(posedge clk24) begin
    if (rst) begin
      for (int i = 0; i < NVOICES; i++) rank_q[i] <= IW'(i);
    end else if (touch) begin
      for (int i = 0; i < NVOICES; i++) begin
        if (IW'(i) == touch_idx)
          rank_q[i] <= '0;
        else if (rank_q[i] < old_rank)
          rank_q[i] <= rank_q[i] + IW'(1);
      end
    end
  end

  for (genvar g = 0; g < NVOICES; g++) begin : g_ranks
    assign ranks[g*IW +: IW] = rank_q[g];
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off events onto NVOICES gates with
// retrigger, free-voice and LRU-steal policies, plus a forced gate-low gap.
module voice_alloc
  import synth_pkg::*;
#(
  parameter int NVOICES    = NVOICES_DEF,
  parameter int RETRIG_GAP = RETRIG_GAP_DEF
) (
  input  logic                      clk24,
  input  logic                      rst,
  voice_alloc_if.slave              ev,
  input  logic                      all_off,
  output logic [NVOICES-1:0]        trig,
  output logic [NVOICES*FREQ_W-1:0] freq,
  output logic                      busy
);

  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam int GW = $clog2(RETRIG_GAP + 1);

  logic [1:0]        state;
  event_t            cap;
  logic [NOTE_W-1:0] note_q [NVOICES];
  logic [FREQ_W-1:0] freq_q [NVOICES];
  logic [NVOICES-1:0] gate;
  logic [IW-1:0]     sel_idx;
  logic              sel_gated;
  logic              sel_hit;
  logic [GW-1:0]     gap_cnt;

  logic [NVOICES*IW-1:0] ranks;
  logic              lru_touch;

  logic              match_found;
  logic [IW-1:0]     match_idx;
  logic              free_found;
  logic [IW-1:0]     free_idx;
  logic [IW-1:0]     oldest_idx;

  assign ev.ev_ready = (state == ST_IDLE) && !rst && !all_off;
  assign busy        = (state != ST_IDLE) && !rst;
  assign trig        = gate;
  assign lru_touch   = (state == ST_APPLY) && cap.on && !all_off && !rst;

  for (genvar g = 0; g < NVOICES; g++) begin : g_freq
    assign freq[g*FREQ_W +: FREQ_W] = freq_q[g];
  end

  // Scanning downwards lets the lowest matching index win.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    oldest_idx  = '0;
    for (int i = NVOICES - 1; i >= 0; i--) begin
      if (gate[i] && (note_q[i] == cap.note)) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
      end
      if (!gate[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (ranks[i*IW +: IW] == IW'(NVOICES - 1)) oldest_idx = IW'(i);
    end
  end

  always_ff @(posedge clk24) begin
    if (rst) begin
      state     <= ST_IDLE;
      cap       <= '0;
      gate      <= '0;
      sel_idx   <= '0;
      sel_gated <= 1'b0;
      sel_hit   <= 1'b0;
      gap_cnt   <= '0;
      for (int i = 0; i < NVOICES; i++) begin
        note_q[i] <= '0;
        freq_q[i] <= '0;
      end
    end else if (all_off) begin
      state   <= ST_IDLE;
      gate    <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ev.ev_valid) begin
            cap   <= '{on: ev.ev_on, note: ev.ev_note, freq: ev.ev_freq};
            state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          sel_hit <= match_found;
          if (!cap.on || match_found) begin
            sel_idx   <= match_idx;
            sel_gated <= 1'b1;
          end else if (free_found) begin
            sel_idx   <= free_idx;
            sel_gated <= 1'b0;
          end else begin
            sel_idx   <= oldest_idx;
            sel_gated <= 1'b1;
          end
          state <= ST_APPLY;
        end
        ST_APPLY: begin
          state <= ST_IDLE;
          if (cap.on) begin
            note_q[sel_idx] <= cap.note;
            freq_q[sel_idx] <= cap.freq;
            if (sel_gated) begin
              gate[sel_idx] <= 1'b0;
              gap_cnt       <= GW'(RETRIG_GAP);
              state         <= ST_GAP;
            end else begin
              gate[sel_idx] <= 1'b1;
            end
          end else if (sel_hit) begin
            gate[sel_idx] <= 1'b0;
          end
        end
        ST_GAP: begin
          // Counter holds the number of gate-low cycles still owed.
          if (gap_cnt <= GW'(1)) begin
            gate[sel_idx] <= 1'b1;
            gap_cnt       <= '0;
            state         <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  voice_lru #(.NVOICES(NVOICES)) u_lru (
    .clk24     (clk24),
    .rst       (rst),
    .touch     (lru_touch),
    .touch_idx (sel_idx),
    .ranks     (ranks)
  );

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter NVOICES, default 3: number of voices allocated.
REQ-002 Parameter RETRIG_GAP, default 512: gate-low cycles forced before a retrigger (one 48 kHz sample at 24.576 MHz).
REQ-003 clk24  input  1  synthesis clock; the block has one clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ev_valid  input  1  note event present.
REQ-006 ev_ready  output  1  block accepts an event this cycle.
REQ-007 ev_on  input  1  1 = note-on, 0 = note-off.
REQ-008 ev_note  input  7  MIDI note number.
REQ-009 ev_freq  input  16  oscillator frequency word for ev_note; used on note-on only.
REQ-010 all_off  input  1  panic: clear every gate.
REQ-011 trig  output  NVOICES  per-voice gate, drives voice trig.
REQ-012 freq  output  NVOICES*16  per-voice frequency word; voice i at bits [16i+15:16i].
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Per voice, the block SHALL hold a note register (7 bits), a frequency register (16 bits), a gate bit and an LRU rank (0 = most recently assigned).
REQ-015 The FSM SHALL have states IDLE, LOOKUP, APPLY and GAP; ev_ready SHALL be 1 only in IDLE.
REQ-016 An event SHALL be accepted when ev_valid and ev_ready are both 1; ev_on, ev_note and ev_freq SHALL be captured on that edge, and the state SHALL move to LOOKUP.
REQ-017 LOOKUP SHALL take one cycle: compare the captured note against all gated voices, find the lowest-index ungated voice, and find the voice with the highest LRU rank.
REQ-018 Note-on voice choice, in priority order: (a) gated voice already holding the note (retrigger); (b) lowest-index ungated voice; (c) highest-rank voice (steal).
REQ-019 Note-on to an ungated voice: in APPLY, write freq and note, set gate, make the voice rank 0 and increment every rank below its old rank, then return to IDLE; trig SHALL rise 2 cycles after the accept edge.
REQ-020 Note-on to a gated voice (retrigger or steal): in APPLY, clear gate, write freq, note and rank, enter GAP for RETRIG_GAP cycles, set gate on GAP exit, then return to IDLE.
REQ-021 Note-off: in APPLY, clear the gate of the gated voice holding that note; freq, note and ranks SHALL be left unchanged; return to IDLE.
REQ-022 A note-off that matches no gated voice SHALL change nothing and SHALL return to IDLE after APPLY.
REQ-023 LRU ranks SHALL always form a permutation of 0..NVOICES-1.
REQ-024 all_off SHALL, on the next edge, clear all gates and force IDLE from any state. It SHALL take priority over an event presented in the same cycle, which is not accepted. If all_off arrives during GAP, the pending gate SHALL NOT be set.
REQ-025 The GAP counter SHALL be wide enough for RETRIG_GAP and SHALL NOT wrap; it SHALL be reloaded on each GAP entry.

Reset
REQ-026 While rst is high, the block SHALL hold: state IDLE, trig 0, freq 0, note registers 0, ranks equal to voice index, and GAP counter 0.
REQ-027 ev_ready and busy SHALL be 0 during reset. ev_ready SHALL be 1 and busy 0 on the first cycle after reset.
REQ-028 rst asserted mid-GAP or mid-APPLY SHALL abort the operation with no gate set.

Structure
REQ-029 A shared package synth_pkg SHALL hold the NVOICES default, the state encoding, the note and frequency widths, and the 24.576 MHz / 48 kHz derived RETRIG_GAP constant.
REQ-030 LRU rank update SHALL be a sub-module voice_lru. Its inputs SHALL be the touched voice index and a strobe; its output SHALL be the rank vector.

Verification
REQ-031 Reset, then note-on 60 with freq 0x1234 -> trig=001 and freq[15:0]=0x1234 two cycles after accept; ev_ready returns high the next cycle.
REQ-032 Note-on 60, 62 and 64, then note-on 67 -> voice 0 (oldest) is stolen: trig[0] low for exactly 512 cycles, then high with the 67 freq word; voices 1 and 2 are untouched.
REQ-033 Note-on 60 twice -> the second event retriggers voice 0 (gap of 512 cycles); voices 1 and 2 stay ungated.
REQ-034 Note-on 60 and 62, note-off 60, then note-on 64 -> voice 0 reused for 64; note-off 61 produces no change.
REQ-035 all_off asserted 100 cycles into a GAP, with ev_valid high in the same cycle -> trig=000 next cycle, state IDLE, event not accepted, gate never set.
REQ-036 rst pulsed during APPLY and during GAP -> all outputs at reset values and ranks back to 0, 1, 2.
